// File: rtl/shift_tx_pkg.sv
// Shared types and helpers for the shift_tx_sched slice: FSM states,
// frame delimiter bits and the frame builder used at capture time.
package shift_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int MAX_DATA_W = 32;
  localparam int MAX_FRAME_W = MAX_DATA_W + 2;

  // Result is {STOP_BIT, payload, START_BIT} right-aligned; caller truncates to its frame width.
  function automatic logic [MAX_FRAME_W-1:0] build_frame(input logic [MAX_DATA_W-1:0] data,
                                                         input int unsigned data_w);
    logic [MAX_DATA_W-1:0] mask;
    mask = ~({MAX_DATA_W{1'b1}} << data_w);
    build_frame = {1'b0, data & mask, START_BIT} | (MAX_FRAME_W'(STOP_BIT) << (data_w + 1));
  endfunction

endpackage

// File: rtl/shift_tx_sched_rr_arbiter.sv
// Combinational round-robin picker: searches from last+1 upward, wrapping
// modulo N, and returns the first requester found.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);

  localparam int IW = $clog2(N);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_i) + k) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/shift_tx_sched.sv
// Round-robin scheduler sharing one frame serializer among N_REQ requesters:
// captures and frames the winner's word, issues load, counts ShiftR to completion.
module shift_tx_sched
  import shift_tx_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 8,
  parameter int FRAME_BITS = 10,
  parameter int TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   data_in,
  input  logic                      Sample_Enable,
  input  logic                      ShiftR,
  output logic                      load,
  output logic [FRAME_BITS-1:0]     frame,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(N_REQ)-1:0]  done_id,
  output logic                      err
);

  localparam int IW  = $clog2(N_REQ);
  localparam int SCW = $clog2(FRAME_BITS + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  if (FRAME_BITS != DATA_W + 2) begin : g_bad_frame_bits
    $error("shift_tx_sched: FRAME_BITS must equal DATA_W+2");
  end
  if (DATA_W > MAX_DATA_W) begin : g_bad_data_w
    $error("shift_tx_sched: DATA_W exceeds MAX_DATA_W");
  end

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [N_REQ-1:0]      grant_q, grant_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         done_id_q, done_id_d;
  logic [SCW-1:0]        shift_cnt_q, shift_cnt_d;
  logic [TCW-1:0]        to_cnt_q, to_cnt_d;
  logic                  err_q, err_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_valid;
  logic [DATA_W-1:0] words [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign words[g] = data_in[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i   (req),
    .last_i  (last_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    last_d      = last_q;
    done_id_d   = done_id_q;
    shift_cnt_d = shift_cnt_q;
    to_cnt_d    = to_cnt_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          frame_d     = FRAME_BITS'(build_frame(MAX_DATA_W'(words[arb_idx]), DATA_W));
          grant_d     = arb_gnt;
          owner_d     = arb_idx;
          shift_cnt_d = '0;
          to_cnt_d    = '0;
          state_d     = LOAD;
        end
      end
      LOAD: state_d = SHIFT;
      SHIFT: begin
        // ShiftR takes precedence over a coincident Sample_Enable tick.
        if (ShiftR) begin
          shift_cnt_d = shift_cnt_q + SCW'(1);
          to_cnt_d    = '0;
          if (shift_cnt_q == SCW'(FRAME_BITS - 1)) begin
            err_d     = 1'b0;
            done_id_d = owner_q;
            state_d   = DONE;
          end
        end else if (Sample_Enable) begin
          if (to_cnt_q == TCW'(TIMEOUT - 1)) begin
            err_d     = 1'b1;
            done_id_d = owner_q;
            state_d   = DONE;
          end else begin
            to_cnt_d = to_cnt_q + TCW'(1);
          end
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      grant_q     <= '0;
      owner_q     <= '0;
      last_q      <= IW'(N_REQ - 1);
      done_id_q   <= '0;
      shift_cnt_q <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      done_id_q   <= done_id_d;
      shift_cnt_q <= shift_cnt_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
    end
  end

  assign load    = (state_q == LOAD);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign err     = done && err_q;
  assign grant   = busy ? grant_q : '0;
  assign frame   = frame_q;
  assign done_id = done_id_q;

endmodule

// File: doc/shift_tx_sched.md
# shift_tx_sched

Round-robin scheduler that shares one frame serializer (parallel-load shift register plus `pulse_gen`) among `N_REQ` requesters. It captures the winning requester's data word, frames it with start and stop bits, and issues the one-cycle `load`. It then counts the `ShiftR` pulses coming back from `pulse_gen` until the frame is fully shifted out, and reports completion (or a stall timeout) to the requester. It sits between the client blocks and the serializer datapath.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 8: payload bits per frame.
- `FRAME_BITS`, default 10: shifted bits per frame. Must equal `DATA_W+2`; elaboration fails otherwise.
- `TIMEOUT`, default 16: `Sample_Enable` ticks allowed without a `ShiftR` before a frame is aborted.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req` in `N_REQ`: per-requester transmit request, level.
- `data_in` in `N_REQ*DATA_W`: requester i's word is `data_in[i*DATA_W +: DATA_W]`.
- `Sample_Enable` in 1: bit-rate tick, the same signal that feeds `pulse_gen`.
- `ShiftR` in 1: shift pulse from `pulse_gen`.
- `load` out 1: one-cycle parallel-load strobe to the serializer and `pulse_gen`.
- `frame` out `FRAME_BITS`: parallel load value `{1'b1, data, 1'b0}` (stop, payload, start). LSB is shifted first.
- `grant` out `N_REQ`: one-hot owner of the serializer. Asserted from the LOAD state through the DONE state.
- `busy` out 1: high when state != IDLE.
- `done` out 1: one-cycle completion pulse.
- `done_id` out `$clog2(N_REQ)`: requester index for the frame just completed. Held until the next `done`.
- `err` out 1: qualifies `done`. High means the frame was aborted on timeout.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - If `req` != 0, pick the winner by round-robin. Search starts at `last+1` and wraps modulo `N_REQ`.
  - Capture the winner's word into `frame`, latch the index, clear the shift and timeout counters, then go to LOAD.
  - If `req` == 0, stay in IDLE.
- LOAD:
  - `load` = 1 for this cycle only. Go to SHIFT unconditionally.
- SHIFT:
  - `shift_cnt` increments on each `ShiftR`. It is `$clog2(FRAME_BITS+1)` bits wide and never wraps.
  - `ShiftR` with `shift_cnt == FRAME_BITS-1` goes to DONE with `err` = 0.
  - `to_cnt` increments on each `Sample_Enable` cycle without `ShiftR`, and clears on `ShiftR`.
  - `to_cnt == TIMEOUT-1` with another such tick goes to DONE with `err` = 1.
  - If `ShiftR` and `Sample_Enable` arrive together, `ShiftR` wins: the timeout counter clears.
- DONE:
  - `done` = 1; `done_id` = owner; `last` = owner. Go to IDLE.
- Requester handshake:
  - `data_in` is sampled only in the IDLE cycle that selects the winner. It may change from the first `grant` cycle onward.
  - `req` falling mid-frame is ignored: the frame completes.
  - `req` still high after `done` is simply re-arbitrated. Round-robin guarantees the other pending requesters are served first.
- `ShiftR` outside SHIFT is ignored. It is counted only while in SHIFT.
- Reset values: state IDLE; `load`, `grant`, `busy`, `done`, `err` = 0; `frame` = 0; `done_id` = 0; `last` = `N_REQ-1`, so requester 0 has first priority after reset.
- `rst` mid-frame aborts immediately, with no `done` pulse. The serializer is re-armed by the next `load`.

## Timing
- `req` rising in an IDLE cycle t gives `grant` and `load` at t+1. `frame` is valid at t+1 and stays stable until the next LOAD.
- 10th `ShiftR` at cycle s gives `done` at s+1. The earliest next `load` is s+3 (DONE, IDLE, LOAD).
- All outputs are Moore-decoded from registered state and latches. There is no combinational path from inputs to outputs.

## Structure
- Package `shift_tx_pkg` holds:
  - the FSM state enum;
  - the `START_BIT=1'b0` and `STOP_BIT=1'b1` constants;
  - a function that builds the frame from a data word.
- Sub-module `rr_arbiter` (parameter `N`): combinational round-robin pick from `req` and `last`. It outputs the one-hot winner, its index, and a valid flag.
- Counters, framing and the FSM live in `shift_tx_sched`.

## Test plan
- Single request: `req`=4'b0010, word1=8'hA5 → `grant`=0010 and `load` one cycle later, `frame`=10'b1_1010_0101_0. After 10 `ShiftR`, `done`=1, `done_id`=1, `err`=0.
- Round-robin: `req`=4'b1111 held, all frames completed → grant order 0,1,2,3,0. No index is repeated before all four have been served.
- Timeout: stop `ShiftR` after 3 pulses and keep `Sample_Enable` toggling → `done`=1 with `err`=1 after exactly 16 enable ticks.
- Same-cycle tie: `ShiftR` and `Sample_Enable` high together during SHIFT → timeout counter clears and no abort occurs.
- Reset mid-frame: `rst` after 5 `ShiftR` → next cycle is IDLE with all outputs 0 and no `done`. The next arbitration favours requester 0.
- Request drop and data change: `req` falls and `data_in` changes during SHIFT → frame unchanged, `done` still asserted.
